// File: rtl/stopwatch_btn_ctrl.sv
// Four-button front end for a stopwatch: synchronise, debounce and arm each button, then emit prioritised single-cycle commands.
// Optional long-press clear on the stop button is enabled by defining STOPWATCH_LONGPRESS_CLR_EN.
module stopwatch_btn_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] HOLD_CYCLES     = 32'd100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_raw,
  input  logic       btn_lap_raw,
  input  logic       btn_stop_raw,
  input  logic       btn_clr_raw,
  output logic       start,
  output logic       lap,
  output logic       stop,
  output logic       clr,
  output logic [3:0] btn_level
);

  localparam int CNT_W = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam int ARM_W = $clog2(int'(DEBOUNCE_CYCLES) + 2);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
  // The two reset-cleared sync stages read as low, so arming needs two samples more than a debounce.
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(DEBOUNCE_CYCLES + 16'd1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2
  } btn_state_e;

  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       level_q, level_d;
  logic [3:0]       req_q, req_d;
  logic [3:0]       pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [ARM_W-1:0] arm_q [4];
  logic [ARM_W-1:0] arm_d [4];
  btn_state_e       state_q [4];
  btn_state_e       state_d [4];
  logic             hold_fire;

  assign raw = {btn_clr_raw, btn_stop_raw, btn_lap_raw, btn_start_raw};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    req_d   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]   = '0;
      arm_d[i]   = '0;
      state_d[i] = state_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) level_d[i] = ~level_q[i];
        else                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
      end
      case (state_q[i])
        DISARMED: begin
          if (!level_q[i] && !sync2_q[i]) begin
            if (arm_q[i] == ARM_LAST) state_d[i] = IDLE;
            else                      arm_d[i]   = arm_q[i] + ARM_W'(1);
          end
        end
        IDLE: begin
          if (level_q[i]) begin
            state_d[i] = PRESSED;
            req_d[i]   = 1'b1;
          end
        end
        PRESSED: begin
          if (!level_q[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = DISARMED;
      endcase
    end
    req_d[3] = req_d[3] | hold_fire;
  end

  // Lower-priority requests that collide with a higher one are simply lost.
  always_comb begin
    pulse_d = 4'b0000;
    if (req_q[3])      pulse_d = 4'b1000;
    else if (req_q[2]) pulse_d = 4'b0100;
    else if (req_q[1]) pulse_d = 4'b0010;
    else if (req_q[0]) pulse_d = 4'b0001;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      req_q   <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]   <= '0;
        arm_q[i]   <= '0;
        state_q[i] <= DISARMED;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      req_q   <= req_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]   <= cnt_d[i];
        arm_q[i]   <= arm_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

`ifdef STOPWATCH_LONGPRESS_CLR_EN
  logic [31:0] hold_q, hold_d;

  // Saturates at HOLD_CYCLES so a long hold fires exactly once until stop is released.
  always_comb begin
    hold_d    = '0;
    hold_fire = 1'b0;
    if (state_q[2] == PRESSED && level_q[2]) begin
      hold_d    = (hold_q == HOLD_CYCLES) ? hold_q : hold_q + 32'd1;
      hold_fire = (hold_q == HOLD_CYCLES - 32'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign hold_fire = 1'b0;
`endif

  assign {clr, stop, lap, start} = pulse_q;
  assign btn_level               = level_q;

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Self-checking bench for stopwatch_btn_ctrl with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=20.
// Directed scenarios plus a randomized run compared against a history-based behavioural model.
module tb_stopwatch_btn_ctrl;

  localparam int D   = 4;
  localparam int H   = 20;
  localparam int OFF = 32;
  localparam int NR  = 400;
  localparam int TOT = OFF + NR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start_raw = 1'b0;
  logic       btn_lap_raw = 1'b0;
  logic       btn_stop_raw = 1'b0;
  logic       btn_clr_raw = 1'b0;
  logic       start, lap, stop, clr;
  logic [3:0] btn_level;
  logic [3:0] pulses;

  int checks = 0;
  int failures = 0;

  bit raw_h [4][TOT];
  bit lvl_h [4][TOT];

  assign pulses = {clr, stop, lap, start};

  always #5 clk = ~clk;

  stopwatch_btn_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .HOLD_CYCLES    (32'd20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_start_raw(btn_start_raw),
    .btn_lap_raw  (btn_lap_raw),
    .btn_stop_raw (btn_stop_raw),
    .btn_clr_raw  (btn_clr_raw),
    .start        (start),
    .lap          (lap),
    .stop         (stop),
    .clr          (clr),
    .btn_level    (btn_level)
  );

  // One active edge, then park on the falling edge where outputs are sampled and inputs driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_raw(input logic [3:0] v);
    {btn_clr_raw, btn_stop_raw, btn_lap_raw, btn_start_raw} = v;
  endtask

  task automatic idle(input int n);
    set_raw(4'b0000);
    repeat (n) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_p;
    rst_n = 1'b0;
    set_raw(4'($urandom));
    step();
    step();
    checks++;
    if (pulses !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_pulses: got %b expected %b", pulses, 4'b0000);
    end
    checks++;
    if (btn_level !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_level: got %b expected %b", btn_level, 4'b0000);
    end
    set_raw(4'b0000);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (pulses !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL arm_quiet k=%0d: got %b expected %b", k, pulses, 4'b0000);
      end
    end
    // Reset in the middle of a debounce, button kept held afterwards.
    set_raw(4'b0001);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    checks++;
    if ({btn_level, pulses} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_debounce_reset: got %b expected %b", {btn_level, pulses}, 8'h00);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      checks++;
      if (pulses !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL mid_debounce_no_pulse k=%0d: got %b expected %b", k, pulses, 4'b0000);
      end
    end
    idle(16);
    // Reset on the very edge that would have produced the pulse.
    set_raw(4'b0001);
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if (pulses !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL pre_reset_edge k=%0d: got %b expected %b", k, pulses, 4'b0000);
      end
    end
    rst_n = 1'b0;
    step();
    exp_p = 4'b0000;
    checks++;
    if ({btn_level, pulses} !== {4'b0000, exp_p}) begin
      failures++;
      $display("[TB] FAIL reset_beats_pulse: got %b expected %b", {btn_level, pulses}, {4'b0000, exp_p});
    end
    rst_n = 1'b1;
    idle(14);
  endtask

  task automatic test_start_latency();
    logic [3:0] exp_p, exp_l;
    set_raw(4'b0001);
    for (int k = 0; k < 14; k++) begin
      step();
      exp_p = (k == D + 3) ? 4'b0001 : 4'b0000;
      exp_l = (k >= D + 1) ? 4'b0001 : 4'b0000;
      checks++;
      if (pulses !== exp_p) begin
        failures++;
        $display("[TB] FAIL start_pulse k=%0d: got %b expected %b", k, pulses, exp_p);
      end
      checks++;
      if (btn_level !== exp_l) begin
        failures++;
        $display("[TB] FAIL start_level k=%0d: got %b expected %b", k, btn_level, exp_l);
      end
    end
    idle(14);
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 26; k++) begin
      set_raw({2'b00, (k < 12) && ((k / 2) % 2 == 0), 1'b0});
      step();
      checks++;
      if ({btn_level, pulses} !== 8'h00) begin
        failures++;
        $display("[TB] FAIL lap_glitch k=%0d: got %b expected %b", k, {btn_level, pulses}, 8'h00);
      end
    end
  endtask

  task automatic test_coincident();
    logic [3:0] exp_p;
    set_raw(4'b0110);
    for (int k = 0; k < 12; k++) begin
      step();
      exp_p = (k == D + 3) ? 4'b0100 : 4'b0000;
      checks++;
      if (pulses !== exp_p) begin
        failures++;
        $display("[TB] FAIL stop_lap_pulse k=%0d: got %b expected %b", k, pulses, exp_p);
      end
    end
    checks++;
    if (btn_level !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL stop_lap_level: got %b expected %b", btn_level, 4'b0110);
    end
    idle(14);
  endtask

  task automatic test_reset_hold();
    logic [3:0] exp_p;
    set_raw(4'b1000);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (pulses !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL clr_held_reset k=%0d: got %b expected %b", k, pulses, 4'b0000);
      end
    end
    checks++;
    if (btn_level !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL clr_held_level: got %b expected %b", btn_level, 4'b1000);
    end
    set_raw(4'b0000);
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (pulses !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL clr_release k=%0d: got %b expected %b", k, pulses, 4'b0000);
      end
    end
    set_raw(4'b1000);
    for (int k = 0; k < 12; k++) begin
      step();
      exp_p = (k == D + 3) ? 4'b1000 : 4'b0000;
      checks++;
      if (pulses !== exp_p) begin
        failures++;
        $display("[TB] FAIL clr_repress k=%0d: got %b expected %b", k, pulses, exp_p);
      end
    end
    idle(14);
  endtask

  task automatic test_longpress();
    logic [3:0] exp_p;
    for (int k = 0; k < 60; k++) begin
      set_raw((k < 40) ? 4'b0100 : 4'b0000);
      step();
      exp_p = 4'b0000;
      if (k == D + 3) exp_p = 4'b0100;
`ifdef STOPWATCH_LONGPRESS_CLR_EN
      if (k == D + 3 + H) exp_p = 4'b1000;
`endif
      checks++;
      if (pulses !== exp_p) begin
        failures++;
        $display("[TB] FAIL longpress k=%0d: got %b expected %b", k, pulses, exp_p);
      end
    end
    idle(14);
  endtask

  // Model: the debounced level flips once the last D synced samples (raw delayed two edges)
  // all disagree with it; a 0->1 flip yields a command two edges later, clr > stop > lap > start.
  task automatic test_random();
    int         rem [4];
    bit         cur [4];
    bit         prev, tog, held;
    logic [3:0] rise, exp_p, exp_l;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(12);
    for (int b = 0; b < 4; b++) begin
      rem[b] = 0;
      cur[b] = 1'b0;
      for (int t = 0; t < TOT; t++) begin
        raw_h[b][t] = 1'b0;
        lvl_h[b][t] = 1'b0;
      end
    end
    for (int t = OFF; t < TOT; t++) begin
      for (int b = 0; b < 4; b++) begin
        if (rem[b] == 0) begin
          cur[b] = 1'($urandom_range(0, 1));
          rem[b] = int'($urandom_range(1, 12));
        end
        rem[b]--;
        raw_h[b][t] = cur[b];
      end
      set_raw({cur[3], cur[2], cur[1], cur[0]});
      step();
      for (int b = 0; b < 4; b++) begin
        prev = lvl_h[b][t-1];
        tog  = 1'b1;
        for (int k = 0; k < D; k++)
          if (raw_h[b][t-2-k] == prev) tog = 1'b0;
        lvl_h[b][t] = tog ? ~prev : prev;
        exp_l[b]    = lvl_h[b][t];
        rise[b]     = lvl_h[b][t-2] && !lvl_h[b][t-3];
      end
`ifdef STOPWATCH_LONGPRESS_CLR_EN
      if (t - H - 3 >= 0) begin
        held = !lvl_h[2][t-H-3];
        for (int k = t - H - 2; k <= t - 2; k++)
          if (!lvl_h[2][k]) held = 1'b0;
        if (held) rise[3] = 1'b1;
      end
`else
      held = 1'b0;
      if (held) rise[3] = 1'b1;
`endif
      if (rise[3])      exp_p = 4'b1000;
      else if (rise[2]) exp_p = 4'b0100;
      else if (rise[1]) exp_p = 4'b0010;
      else if (rise[0]) exp_p = 4'b0001;
      else              exp_p = 4'b0000;
      checks++;
      if (btn_level !== exp_l) begin
        failures++;
        $display("[TB] FAIL random_level t=%0d: got %b expected %b", t - OFF, btn_level, exp_l);
      end
      checks++;
      if (pulses !== exp_p) begin
        failures++;
        $display("[TB] FAIL random_pulse t=%0d: got %b expected %b", t - OFF, pulses, exp_p);
      end
    end
    idle(14);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start_latency();
    test_glitch();
    test_coincident();
    test_reset_hold();
    test_longpress();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_btn_ctrl.md
STOPWATCH_BTN_CTRL -- requirements
Module: stopwatch_btn_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles required to accept a level change (min 2).
REQ-002 Parameter: HOLD_CYCLES, 32'd100000000, continuous debounced-high cycles on stop that generate a long-press clear (used only with REQ-024).
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 Port: btn_start_raw, btn_lap_raw, btn_stop_raw, btn_clr_raw  input  1 each  asynchronous raw push-buttons, active-high, may bounce.
REQ-006 Port: start, lap, stop, clr  output  1 each  registered single-cycle command pulses to the stopwatch core.
REQ-007 Port: btn_level  output  4  registered debounced levels {clr,stop,lap,start}.

Function
REQ-008 Each raw input SHALL pass through a 2-flop synchronizer before any other use.
REQ-009 Each button SHALL have an independent debounce counter, width $clog2(DEBOUNCE_CYCLES+1).
- Counter increments while synced input differs from debounced level.
- Counter clears to 0 on any cycle where they agree (a glitch restarts the count).
- When the count reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
REQ-010 A command pulse SHALL be generated only on a debounced 0->1 transition; release (1->0) SHALL NOT generate a pulse.
REQ-011 Latency: for a clean raw rise first sampled at edge N, the pulse SHALL be high for exactly the one cycle following edge N+DEBOUNCE_CYCLES+3.
REQ-012 A button held high SHALL produce exactly one pulse until released (debounced low) and pressed again.
REQ-013 Bursts shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no pulse and no change in btn_level.
REQ-014 At most one of start/lap/stop/clr SHALL be high in any cycle; priority clr > stop > lap > start.
REQ-015 A lower-priority qualifying edge that coincides with a higher-priority one SHALL be dropped, not queued; its debounced level still updates.
REQ-016 Each button SHALL run the state machine DISARMED -> IDLE -> PRESSED -> IDLE.
- DISARMED: no pulse; go to IDLE when the debounced level is low.
- IDLE: on a debounced rise go to PRESSED and request a pulse.
- PRESSED: go to IDLE on a debounced fall.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 On a clk edge with rst_n=0: synchronizer flops, counters, and debounced levels SHALL become 0, and all buttons SHALL enter DISARMED.
REQ-019 On the same edge, start, lap, stop, clr, and btn_level SHALL become 0, and the hold counter SHALL clear.
REQ-020 A button held high through reset release SHALL NOT produce a pulse until it is released and re-pressed.
REQ-021 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be issued for that press.
REQ-022 A reset edge coinciding with a qualifying edge SHALL take priority; outputs SHALL be 0 on that edge.

Configuration
REQ-023 Macro STOPWATCH_LONGPRESS_CLR_EN selects the long-press clear feature.
REQ-024 Defined: a hold counter SHALL run while stop is debounced-high in PRESSED.
- When it reaches HOLD_CYCLES, one clr pulse SHALL be issued, subject to REQ-014 priority.
- No further clr SHALL follow until stop is released.
- The counter clears on release.
REQ-025 Not defined: no hold counter SHALL be synthesized, and HOLD_CYCLES SHALL be ignored; clr comes only from btn_clr_raw.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20)
REQ-026 btn_start_raw clean rise at edge 10, held -> start high only in the cycle after edge 17; btn_level[0]=1 from then on.
REQ-027 btn_lap_raw toggling every 2 cycles for 12 cycles, then low -> lap never pulses; btn_level[1] stays 0.
REQ-028 btn_stop_raw and btn_lap_raw rise on the same edge -> stop pulses once, lap never pulses, btn_level[2:1]=2'b11.
REQ-029 btn_clr_raw held high while rst_n goes low then high -> no clr pulse; after release and re-press, one clr pulse 7 edges after the re-press.
REQ-030 With STOPWATCH_LONGPRESS_CLR_EN: stop held 40 cycles -> one stop pulse, then exactly one clr pulse 20 cycles later. Without the macro -> stop pulse only.
